// File: rtl/fm_pkg.sv
// -----------------------------------------------------------------------------
// fm_pkg
// Shared definitions for the FM receive blocks: meter state encoding,
// period-class encoding, default short/long period lengths and the period
// classification helper.
// -----------------------------------------------------------------------------
package fm_pkg;

    // Default period lengths (in clk cycles) produced by the fractional divider.
    localparam int SHORT_LEN_DEF = 4;
    localparam int LONG_LEN_DEF  = 5;

    // Measurement state machine encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQ     = 2'd1,
        MEASURE = 2'd2
    } fm_state_t;

    // Classification of one measured input period.
    typedef enum logic [1:0] {
        SHORT   = 2'd0,
        LONG    = 2'd1,
        ILLEGAL = 2'd2
    } fm_class_t;

    // Map a measured period length onto its class.
    function automatic fm_class_t classify_period(
        input logic [2:0] period,
        input logic [2:0] short_len,
        input logic [2:0] long_len
    );
        fm_class_t cls;
        if (period == short_len) begin
            cls = SHORT;
        end else if (period == long_len) begin
            cls = LONG;
        end else begin
            cls = ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fm_period_classify.sv
// -----------------------------------------------------------------------------
// fm_period_classify
// Rising-edge detector plus 3-bit interval counter for a clk-synchronous pulse
// train. At every rising edge the period just completed (counter value before
// reload) is classified as SHORT, LONG or ILLEGAL.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   nclk_in      in   pulse train, synchronous to clk
//   pulse_edge   out  high in the cycle a rising edge of nclk_in is seen
//   period_class out  class of the period closed by this edge (valid with
//                     pulse_edge)
// -----------------------------------------------------------------------------
module fm_period_classify
    import fm_pkg::*;
#(
    parameter int SHORT_LEN = SHORT_LEN_DEF,
    parameter int LONG_LEN  = LONG_LEN_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      nclk_in,
    output logic      pulse_edge,
    output fm_class_t period_class
);

    localparam logic [2:0] SHORT_P = 3'(SHORT_LEN);
    localparam logic [2:0] LONG_P  = 3'(LONG_LEN);
    localparam logic [2:0] ICNT_MAX = 3'd7;

    logic       in_d;
    logic [2:0] icnt;

    assign pulse_edge = nclk_in & ~in_d;

    // icnt holds the length of the running period; it restarts at 1 on the
    // edge so that at the next edge it equals the full period length.
    assign period_class = classify_period(icnt, SHORT_P, LONG_P);

    // Input delay register and saturating interval counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_d <= 1'b0;
            icnt <= 3'd0;
        end else begin
            in_d <= nclk_in;
            if (pulse_edge) begin
                icnt <= 3'd1;
            end else if (icnt != ICNT_MAX) begin
                icnt <= icnt + 3'd1;
            end else begin
                icnt <= icnt;
            end
        end
    end

endmodule

// File: rtl/fm_period_meter.sv
// -----------------------------------------------------------------------------
// fm_period_meter
// Recovers the programmed factor of a fractional carrier divider by counting
// long (LONG_LEN) periods between consecutive short (SHORT_LEN) periods of the
// divided pulse train. Also flags illegal periods and loss of signal.
//
// Build option:
//   FM_METER_SYNC_EN  when defined, nclk_in passes through a two-flop
//                     synchronizer first (input may be asynchronous; all
//                     latencies grow by 2 clk). Otherwise nclk_in must be
//                     synchronous to clk.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   nclk_in      in   divided-clock pulse train (one clk-wide pulse per period)
//   factor_out   out  last recovered long-period count (FW bits)
//   factor_valid out  one-cycle strobe, factor_out updated this cycle
//   locked       out  consistent pulse train being measured
//   period_err   out  one-cycle strobe, illegal period or counter overflow
//   lost         out  level, no pulse for TIMEOUT cycles
// -----------------------------------------------------------------------------
module fm_period_meter
    import fm_pkg::*;
#(
    parameter int FW        = 16,
    parameter int TIMEOUT   = 64,
    parameter int SHORT_LEN = SHORT_LEN_DEF,
    parameter int LONG_LEN  = LONG_LEN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nclk_in,
    output logic [FW-1:0] factor_out,
    output logic          factor_valid,
    output logic          locked,
    output logic          period_err,
    output logic          lost
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [FW-1:0] LMAX = {FW{1'b1}};

    logic          nclk_int;
    logic          pulse_edge;
    fm_class_t     period_class;

    fm_state_t     state_r,  state_s;
    logic [FW-1:0] lcnt_r,   lcnt_s;
    logic [FW-1:0] factor_r, factor_s;
    logic          valid_r,  valid_s;
    logic          locked_r, locked_s;
    logic          err_r,    err_s;
    logic [TW-1:0] tcnt_r,   tcnt_s;
    logic          lost_r;
    logic          lost_rise_s;

`ifdef FM_METER_SYNC_EN
    logic sync1_r, sync2_r;

    // Two-flop synchronizer for an asynchronous pulse train.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= nclk_in;
            sync2_r <= sync1_r;
        end
    end

    assign nclk_int = sync2_r;
`else
    assign nclk_int = nclk_in;
`endif

    fm_period_classify #(
        .SHORT_LEN (SHORT_LEN),
        .LONG_LEN  (LONG_LEN)
    ) u_classify (
        .clk          (clk),
        .reset        (reset),
        .nclk_in      (nclk_int),
        .pulse_edge   (pulse_edge),
        .period_class (period_class)
    );

    // Timeout counter next value and the cycle in which loss of signal begins.
    always_comb begin
        tcnt_s = tcnt_r;
        if (pulse_edge) begin
            tcnt_s = '0;
        end else if (tcnt_r != TMAX) begin
            tcnt_s = tcnt_r + TW'(1);
        end else begin
            tcnt_s = tcnt_r;
        end
        lost_rise_s = (tcnt_s == TMAX) && (tcnt_r != TMAX);
    end

    // Next-state and next-output logic of the measurement FSM.
    always_comb begin
        state_s  = state_r;
        lcnt_s   = lcnt_r;
        factor_s = factor_r;
        valid_s  = 1'b0;
        err_s    = 1'b0;
        locked_s = locked_r;
        if (lost_rise_s) begin
            state_s  = IDLE;
            locked_s = 1'b0;
            lcnt_s   = '0;
        end else if (pulse_edge) begin
            case (state_r)
                IDLE: begin
                    // First edge only opens a period; nothing to measure yet.
                    state_s = ACQ;
                end
                ACQ: begin
                    case (period_class)
                        SHORT: begin
                            state_s = MEASURE;
                            lcnt_s  = '0;
                        end
                        LONG: begin
                            state_s = ACQ;
                        end
                        default: begin
                            err_s = 1'b1;
                        end
                    endcase
                end
                MEASURE: begin
                    case (period_class)
                        LONG: begin
                            if (lcnt_r == LMAX) begin
                                err_s    = 1'b1;
                                state_s  = IDLE;
                                locked_s = 1'b0;
                                lcnt_s   = '0;
                            end else begin
                                lcnt_s = lcnt_r + FW'(1);
                            end
                        end
                        SHORT: begin
                            factor_s = lcnt_r;
                            valid_s  = 1'b1;
                            lcnt_s   = '0;
                            locked_s = 1'b1;
                        end
                        default: begin
                            err_s    = 1'b1;
                            locked_s = 1'b0;
                            state_s  = ACQ;
                            lcnt_s   = '0;
                        end
                    endcase
                end
                default: begin
                    state_s  = IDLE;
                    locked_s = 1'b0;
                    lcnt_s   = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            lcnt_r   <= '0;
            factor_r <= '0;
            valid_r  <= 1'b0;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
            tcnt_r   <= '0;
            lost_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            lcnt_r   <= lcnt_s;
            factor_r <= factor_s;
            valid_r  <= valid_s;
            locked_r <= locked_s;
            err_r    <= err_s;
            tcnt_r   <= tcnt_s;
            lost_r   <= (tcnt_s == TMAX);
        end
    end

    assign factor_out   = factor_r;
    assign factor_valid = valid_r;
    assign locked       = locked_r;
    assign period_err   = err_r;
    assign lost         = lost_r;

endmodule

// File: doc/fm_period_meter.md
Name: fm_period_meter

Overview:
- Receive-side counterpart of the fractional carrier divider.
- Observes the divided-clock pulse train, one clk-wide pulse per period, each period 4 (short) or 5 (long) clk cycles.
- Classifies every period as short or long and counts long periods between consecutive short ones, recovering the divider's programmed factor.
- Used in loopback self-test and as a digital FM discriminator front end.

Parameters:
- FW, 16, width of recovered factor and long-period counter
- TIMEOUT, 64, clk cycles without an input pulse before declaring loss of signal
- SHORT_LEN, 4, period length in clk cycles classified as short
- LONG_LEN, 5, period length in clk cycles classified as long

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- nclk_in  in  1  divided-clock pulse train, synchronous to clk unless FM_METER_SYNC_EN
- factor_out  out  FW  last recovered long-period count
- factor_valid  out  1  one-cycle strobe: factor_out updated this cycle
- locked  out  1  high while a consistent pulse train is being measured
- period_err  out  1  one-cycle strobe: illegal period length or counter overflow
- lost  out  1  level: no pulse for TIMEOUT cycles

Behaviour:
- One clock (clk). Reset is synchronous and active-high. Reset takes priority over every other event in the same cycle. Reset mid-operation returns to IDLE with no strobe.
- Reset values: factor_out=0, factor_valid=0, locked=0, period_err=0, lost=0; internal state IDLE, icnt=0, lcnt=0.
- Edge detect: registered copy in_d; edge = nclk_in & ~in_d.
- Interval counter icnt (3 bits):
  - Set to 1 on edge; otherwise increments, saturating at 7.
  - At an edge, the measured period P = icnt value before reload.
- Classification at each edge:
  - P==SHORT_LEN -> short.
  - P==LONG_LEN -> long.
  - Anything else -> illegal.
- Timeout counter: cleared on edge, increments otherwise, saturates at TIMEOUT. lost = (tcnt==TIMEOUT).
- States:
  - IDLE: on first edge -> ACQ. P is not evaluated on this edge.
  - ACQ: long -> stay. Short -> MEASURE, lcnt=0. Illegal -> period_err, stay in ACQ.
  - MEASURE:
    - Long -> lcnt+1. lcnt==2^FW-1 -> period_err, IDLE.
    - Short -> factor_out<=lcnt, factor_valid=1, lcnt<=0, locked<=1, stay.
    - Illegal -> period_err, locked<=0, ACQ.
  - Any state, lost rising -> IDLE, locked<=0.
- Latency: factor_valid asserts one clk after the cycle in which the closing short-period edge is seen; factor_out is stable from that cycle until the next update.
- Two adjacent short periods -> factor_out=0, valid strobe.
- period_err and factor_valid are never asserted in the same cycle.

Optional Feature:
- FM_METER_SYNC_EN defined: nclk_in passes through a two-flop synchronizer (reset to 0) before edge detect. All latencies grow by 2 clk; the input may be asynchronous.
- Undefined: nclk_in is used directly and must be synchronous to clk.

Decomposition:
- Shared package fm_pkg: state enum (IDLE, ACQ, MEASURE), SHORT_LEN/LONG_LEN defaults, period-class enum (SHORT, LONG, ILLEGAL).
- One sub-module: fm_period_classify (edge detect + icnt + class output), reusable by other FM receive blocks.

Test Plan:
- Pulse train of 3 long + 1 short repeated (19-cycle frame):
  - factor_valid every 19 cycles, factor_out=3.
  - locked=1 after the second short.
- Factor switch from 3 to 0 (short periods only, 4-cycle pulses) -> factor_out=0, valid every 4 cycles, no period_err.
- Insert one 6-cycle period in MEASURE -> period_err one cycle, locked=0, state ACQ; next short re-syncs, next frame gives the correct factor.
- Stop pulses for 64 cycles -> lost=1 on cycle 64, locked=0; pulses resume -> lost=0 on first edge, relock after two shorts.
- Assert reset for 1 cycle mid-frame with factor_out=3 -> all outputs 0 next cycle, no factor_valid until two shorts are seen.
- With FM_METER_SYNC_EN: repeat the first scenario -> identical values, factor_valid delayed by exactly 2 clk.
